// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder
//   Recovers SAMPLE_W-bit PCM samples from a single-bit PWM stream. It measures
//   the high-time over each PWM period of PERIOD clocks and queues the result
//   in a FIFO. The FIFO is drained through a valid/ready port.
//
//   Optional feature macro: PWM_DEC_DEGLITCH_EN
//     When defined, the synchronized input passes through a 3-tap majority
//     filter. The filter removes 1-cycle pulses and drops, and adds 2 cycles
//     of input latency.
//
//   Ports
//     clk, reset   : clock, synchronous active-high reset
//     enable       : 0 forces IDLE and clears the counters. The FIFO is untouched.
//     pwm_in       : asynchronous PWM input
//     out_data     : registered head-of-FIFO sample (0 when empty)
//     out_valid    : FIFO non-empty
//     out_ready    : consumer accepts the head when out_valid & out_ready
//     fill_level   : FIFO occupancy
//     locked       : high while measuring (MEASURE state)
//     overflow     : sticky. Set when a sample is dropped into a full FIFO.
module pwm_sample_decoder #(
  parameter int PERIOD     = 2268,
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          pwm_in,
  output logic [SAMPLE_W-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          locked,
  output logic                          overflow
);

  localparam int PC_W  = $clog2(PERIOD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0]     LAST = PC_W'(PERIOD - 1);
  localparam logic [SAMPLE_W-1:0] SAT  = '1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MEAS = 1'b1;

  // ---------------- input conditioning ----------------
  logic [1:0] sync_q;
  logic       pwm_s, pwm_s_d, rise;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], pwm_in};
  end

`ifdef PWM_DEC_DEGLITCH_EN
  // The majority of three consecutive samples is registered. Clean edges
  // therefore move 2 cycles later, and any 1-cycle excursion is voted out.
  logic [1:0] hist;
  logic       filt;
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync_q[1]};
      filt <= (sync_q[1] & hist[0]) | (sync_q[1] & hist[1]) | (hist[0] & hist[1]);
    end
  end
  assign pwm_s = filt;
`else
  assign pwm_s = sync_q[1];
`endif

  assign rise = pwm_s & ~pwm_s_d;

  // ---------------- measurement FSM ----------------
  logic [0:0]          state;
  logic [PC_W-1:0]     period_cnt, tmo_cnt;
  logic [SAMPLE_W-1:0] high_cnt, high_inc;
  logic                push;
  logic [SAMPLE_W-1:0] push_data;

  assign high_inc = (high_cnt == SAT) ? SAT : high_cnt + SAMPLE_W'(pwm_s);
  assign locked   = (state == S_MEAS);

  // The push is combinational, so a sample produced this cycle is visible at
  // the FIFO output on the next cycle. The last cycle of a period contributes
  // its own pwm_s to the sample through high_inc.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (enable) begin
      case (state)
        S_IDLE:  push = !rise && (tmo_cnt == LAST);
        S_MEAS: begin
          push      = (period_cnt == LAST);
          push_data = high_inc;
        end
        default: push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      period_cnt <= '0;
      tmo_cnt    <= '0;
      high_cnt   <= '0;
      pwm_s_d    <= 1'b0;
    end else begin
      pwm_s_d <= pwm_s;
      if (!enable) begin
        state      <= S_IDLE;
        period_cnt <= '0;
        tmo_cnt    <= '0;
        high_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) begin
              // The rise cycle itself is the first high cycle of the period.
              state      <= S_MEAS;
              period_cnt <= PC_W'(1);
              high_cnt   <= SAMPLE_W'(1);
              tmo_cnt    <= '0;
            end else if (tmo_cnt == LAST) begin
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + PC_W'(1);
            end
          end
          S_MEAS: begin
            // Free-running after lock: later edges do not re-align the window.
            if (period_cnt == LAST) begin
              period_cnt <= '0;
              high_cnt   <= '0;
            end else begin
              period_cnt <= period_cnt + PC_W'(1);
              high_cnt   <= high_inc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- sample FIFO ----------------
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                pop, full, wr_en;
  logic [SAMPLE_W-1:0] head_nxt;

  assign pop     = out_valid & out_ready;
  assign full    = (fill_level == CNT_W'(FIFO_DEPTH));
  // When the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign wr_en   = push & (~full | pop);
  assign cnt_nxt = fill_level + CNT_W'(wr_en) - CNT_W'(pop);
  assign rd_nxt  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  // If the entry being written becomes the head, forward it. This keeps
  // out_data registered with a single cycle of latency.
  assign head_nxt = (wr_en && wr_ptr == rd_nxt) ? push_data : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_nxt;
      fill_level <= cnt_nxt;
      out_valid  <= (cnt_nxt != '0);
      out_data   <= (cnt_nxt != '0) ? head_nxt : '0;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Testbench for pwm_sample_decoder. Expected samples are queued when a PWM
// period is issued. A forked monitor pops the queue and compares the entry
// with out_data on every accepted output. A short PERIOD keeps the run small.
// The window arithmetic is the same for any PERIOD.
module tb_pwm_sample_decoder;
  localparam int P  = 400;
  localparam int SW = 8;
  localparam int FD = 16;
`ifdef PWM_DEC_DEGLITCH_EN
  localparam int GLITCH_EXP = 100;
`else
  localparam int GLITCH_EXP = 101;
`endif

  logic clk = 1'b0;
  logic reset, enable, pwm_in, out_ready;
  logic out_valid, locked, overflow;
  logic [SW-1:0] out_data;
  logic [$clog2(FD):0] fill_level;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pwm_sample_decoder #(.PERIOD(P), .SAMPLE_W(SW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .locked(locked), .overflow(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outputs are stable from posedge+1 to the next posedge. A handshake that is
  // visible at the negedge is the one the DUT takes on the next edge.
  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_sample: got %0d, no sample expected", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sample", int'(out_data), e);
        end
      end
    end
  endtask

  task automatic drive(input logic v);
    @(posedge clk); #1;
    pwm_in = v;
  endtask

  // One PWM period: high for the first h cycles, an optional 1-cycle pulse at
  // glitch_at, and out_ready dropped at cycle rdy_off (-1 = never).
  task automatic pwm_period(input int h, input int glitch_at, input int rdy_off);
    for (int i = 0; i < P; i++) begin
      @(posedge clk); #1;
      pwm_in = (i < h) || (i == glitch_at);
      if (i == rdy_off) out_ready = 1'b0;
    end
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; pwm_in = 1'b0; out_ready = 1'b1;
    fork monitor(); join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fill_level", fill_level, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;

    // steady tone
    repeat (4) exp_q.push_back(100);
    repeat (4) pwm_period(100, -1, -1);
    chk("tone_locked", locked, 1);

    // saturation: 300-cycle pulses, then constant high
    repeat (4) exp_q.push_back(255);
    repeat (2) pwm_period(300, -1, -1);
    repeat (2) pwm_period(P, -1, -1);
    chk("sat_locked", locked, 1);

    // glitch in the low region of a 100-cycle period
    exp_q.push_back(GLITCH_EXP);
    pwm_period(100, 200, -1);

    // overflow: 17 periods without draining, so the 17th sample is dropped
    repeat (16) exp_q.push_back(50);
    for (int k = 0; k < 17; k++) pwm_period(50, -1, (k == 0) ? 10 : -1);
    exp_q.push_back(0);            // sample of the all-low period that follows
    zeros(10);
    chk("ovf_fill_level", fill_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_out_valid", out_valid, 1);
    out_ready = 1'b1;
    zeros(100);
    chk("drain_fill_level", fill_level, 0);
    chk("drain_overflow_sticky", overflow, 1);
    zeros(P - 110);

    // reset mid-measurement with two samples still queued
    pwm_period(70, -1, 10);
    pwm_period(70, -1, -1);
    zeros(200);
    chk("prerst_fill_level", fill_level, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_fill_level", fill_level, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_overflow", overflow, 0);
    reset = 1'b0;
    out_ready = 1'b1;

    // relock on the next edge
    repeat (2) exp_q.push_back(100);
    repeat (2) pwm_period(100, -1, -1);
    zeros(10);
    chk("relock_locked", locked, 1);

    // enable low drops lock, then silence yields zero samples
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("disable_locked", locked, 0);
    enable = 1'b1;
    repeat (5) exp_q.push_back(0);
    zeros(5 * P + 5);
    chk("silence_locked", locked, 0);
    chk("silence_fill_level", fill_level, 0);

    zeros(5);
    chk("pending_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
